// File: rtl/repeated_subtract_pkg.sv
// Shared types and default widths for the repeated-subtraction divider.
package repeated_subtract_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DW = 10;
    localparam int DEF_VW = 5;

endpackage

// File: rtl/repeated_subtract.sv
// Unsigned divider: subtracts the divisor once per clock until the remainder
// drops below it. Divide-by-zero short-circuits straight to DONE.
module repeated_subtract
    import repeated_subtract_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int VW = DEF_VW
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic [DW-1:0] Dividend,
    input  logic [VW-1:0] Divisor,
    output logic          Ready,
    output logic          Done,
    output logic [DW-1:0] Quotient,
    output logic [VW-1:0] Remainder,
    output logic          DivZero
);

    state_t        r_state;
    state_t        w_next;
    logic [DW-1:0] r_rem;
    logic [VW-1:0] r_dvs;
    logic [DW-1:0] r_q;
    logic          r_divzero;
    logic [DW-1:0] w_dvs_ext;
    logic          w_ge;

    assign w_dvs_ext = {{(DW-VW){1'b0}}, r_dvs};
    assign w_ge      = (r_rem >= w_dvs_ext);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = (Divisor == '0) ? DONE : RUN;
            RUN:     if (!w_ge) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_q       <= '0;
            r_divzero <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_dvs <= Divisor;
                        if (Divisor == '0) begin
                            r_q       <= '1;
                            r_rem     <= '0;
                            r_divzero <= 1'b1;
                        end else begin
                            r_rem     <= Dividend;
                            r_q       <= '0;
                            r_divzero <= 1'b0;
                        end
                    end
                end
                // Exit happens on the first edge where rem < dvs, leaving rem/q untouched
                RUN: begin
                    if (w_ge) begin
                        r_rem <= r_rem - w_dvs_ext;
                        r_q   <= r_q + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // rem < dvs on exit, so the low VW bits carry the whole remainder
    assign Ready     = (r_state == IDLE);
    assign Done      = (r_state == DONE);
    assign Quotient  = r_q;
    assign Remainder = r_rem[VW-1:0];
    assign DivZero   = r_divzero;

endmodule

// File: tb/tb_repeated_subtract.sv
// Directed bench for repeated_subtract: vector table plus reset/ignore/back-to-back sequences.
module tb_repeated_subtract;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [9:0] Dividend = '0;
    logic [4:0] Divisor = '0;
    logic       Ready;
    logic       Done;
    logic [9:0] Quotient;
    logic [4:0] Remainder;
    logic       DivZero;

    int n_checks = 0;
    int n_fail   = 0;

    repeated_subtract #(.DW(10), .VW(5)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Dividend (Dividend),
        .Divisor  (Divisor),
        .Ready    (Ready),
        .Done     (Done),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .DivZero  (DivZero)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [9:0] dvd;
        logic [4:0] dvs;
        logic [9:0] q;
        logic [4:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drive a one-cycle Start, return after the accepting edge (+1).
    task automatic launch(input logic [9:0] dvd, input logic [4:0] dvs, input logic keep_start);
        Dividend = dvd;
        Divisor  = dvs;
        Start    = 1'b1;
        tick();
        if (!keep_start) Start = 1'b0;
        Dividend = 10'($urandom);
        Divisor  = 5'($urandom);
    endtask

    // Count edges after acceptance until Done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int lat;
        vecs[0] = '{10'd100,  5'd7,  10'd14,   5'd2,  1'b0, 15};
        vecs[1] = '{10'd5,    5'd9,  10'd0,    5'd5,  1'b0, 1};
        vecs[2] = '{10'd1023, 5'd1,  10'd1023, 5'd0,  1'b0, 1024};
        vecs[3] = '{10'd50,   5'd0,  10'h3FF,  5'd0,  1'b1, 0};
        vecs[4] = '{10'd0,    5'd5,  10'd0,    5'd0,  1'b0, 1};
        vecs[5] = '{10'd9,    5'd3,  10'd3,    5'd0,  1'b0, 4};
        vecs[6] = '{10'd31,   5'd31, 10'd1,    5'd0,  1'b0, 2};
        vecs[7] = '{10'd1023, 5'd31, 10'd33,   5'd0,  1'b0, 34};
        vecs[8] = '{10'd1000, 5'd17, 10'd58,   5'd14, 1'b0, 59};
        vecs[9] = '{10'd30,   5'd31, 10'd0,    5'd30, 1'b0, 1};

        // Reset state
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_ready", int'(Ready), 1);
        chk("rst_done", int'(Done), 0);
        chk("rst_q", int'(Quotient), 0);
        chk("rst_r", int'(Remainder), 0);
        chk("rst_dz", int'(DivZero), 0);

        // Table-driven divisions
        for (int i = 0; i < 10; i++) begin
            launch(vecs[i].dvd, vecs[i].dvs, 1'b0);
            if (!vecs[i].dz) chk($sformatf("v%0d_busy", i), int'(Ready), 0);
            wait_done(lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_q", i), int'(Quotient), int'(vecs[i].q));
            chk($sformatf("v%0d_r", i), int'(Remainder), int'(vecs[i].r));
            chk($sformatf("v%0d_dz", i), int'(DivZero), int'(vecs[i].dz));
            tick();
            chk($sformatf("v%0d_done_1cyc", i), int'(Done), 0);
            chk($sformatf("v%0d_idle", i), int'(Ready), 1);
            chk($sformatf("v%0d_hold_q", i), int'(Quotient), int'(vecs[i].q));
            chk($sformatf("v%0d_hold_r", i), int'(Remainder), int'(vecs[i].r));
        end

        // Reset at the fifth RUN edge aborts with no Done pulse
        launch(10'd100, 5'd7, 1'b0);
        repeat (4) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_ready", int'(Ready), 1);
        chk("midrst_done", int'(Done), 0);
        chk("midrst_q", int'(Quotient), 0);
        chk("midrst_r", int'(Remainder), 0);
        chk("midrst_dz", int'(DivZero), 0);
        begin
            int seen = 0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (Done) seen = 1;
            end
            chk("midrst_no_done", seen, 0);
        end

        // Reset wins over Start at the same edge
        Reset = 1'b1;
        Start = 1'b1;
        Dividend = 10'd100;
        Divisor = 5'd7;
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        chk("rst_prio_ready", int'(Ready), 1);

        // Start pulsed mid-RUN is ignored
        launch(10'd100, 5'd7, 1'b0);
        begin
            int busy_bad = 0;
            for (int k = 0; k < 3; k++) begin
                if (Ready) busy_bad++;
                tick();
            end
            Start = 1'b1;
            Dividend = 10'd200;
            Divisor = 5'd3;
            if (Ready) busy_bad++;
            tick();
            Start = 1'b0;
            while (!Done && busy_bad < 1000) begin
                if (Ready) busy_bad += 1000;
                tick();
            end
            chk("ign_ready_low", busy_bad, 0);
        end
        chk("ign_q", int'(Quotient), 14);
        chk("ign_r", int'(Remainder), 2);
        tick();

        // Start held high: one IDLE cycle between Done and next load
        launch(10'd9, 5'd3, 1'b1);
        Dividend = 10'd9;
        Divisor = 5'd3;
        wait_done(lat);
        chk("b2b_lat", lat, 4);
        tick();
        chk("b2b_idle", int'(Ready), 1);
        Dividend = 10'd20;
        Divisor = 5'd6;
        tick();
        Start = 1'b0;
        chk("b2b_reload", int'(Ready), 0);
        wait_done(lat);
        chk("b2b2_lat", lat, 4);
        chk("b2b2_q", int'(Quotient), 3);
        chk("b2b2_r", int'(Remainder), 2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/repeated_subtract.md
REPEATED_SUBTRACT -- requirements
Module: repeated_subtract

Interface
REQ-001 SHALL declare parameter DW, default 10: dividend and quotient width.
REQ-002 SHALL declare parameter VW, default 5: divisor and remainder width.
REQ-003 SHALL provide Clock  input  1  sole clock; all state changes on posedge Clock.
REQ-004 SHALL provide Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide Start  input  1  request to begin a division; sampled only in IDLE.
REQ-006 SHALL provide Dividend  input  DW  unsigned dividend; captured when Start is accepted.
REQ-007 SHALL provide Divisor  input  VW  unsigned divisor; captured when Start is accepted.
REQ-008 SHALL provide Ready  output  1  high exactly while in IDLE.
REQ-009 SHALL provide Done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL provide Quotient  output  DW  result quotient.
REQ-011 SHALL provide Remainder  output  VW  result remainder.
REQ-012 SHALL provide DivZero  output  1  high with Done when the captured divisor was 0.

Function
REQ-013 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with Start=1, SHALL load rem<=Dividend (DW bits), dvs<=Divisor, q<=0, DivZero<=0, then go to RUN; if Divisor==0, SHALL instead go to DONE with q<=all ones, rem<=0, DivZero<=1.
REQ-015 In RUN, each edge with rem>=dvs (zero-extended to DW) SHALL do rem<=rem-dvs and q<=q+1; with rem<dvs SHALL go to DONE without updating rem or q.
REQ-016 In DONE, SHALL assert Done for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency: with quotient Q, Done SHALL be high in the cycle following the (Q+1)th rising edge after the edge that accepted Start; divide-by-zero Done SHALL follow that accepting edge directly.
REQ-018 Quotient SHALL equal q, and Remainder SHALL equal rem[VW-1:0] (rem<dvs guarantees fit); both SHALL hold their values from DONE until the next accepted Start.
REQ-019 Start while not in IDLE SHALL be ignored; changes on Dividend/Divisor after acceptance SHALL not affect the result.
REQ-020 Start held high continuously SHALL start a new division on each return to IDLE (one IDLE cycle between Done and the next load).
REQ-021 Arithmetic SHALL be unsigned; q SHALL never wrap (max Q = 2^DW-1 with Divisor=1).

Reset
REQ-022 Reset=1 at a clock edge SHALL force IDLE, Ready=1, Done=0, DivZero=0, Quotient=0, Remainder=0, from any state including mid-RUN.
REQ-023 Reset SHALL take priority over Start at the same edge.

Structure
REQ-024 Package repeated_subtract_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constants DW=10, VW=5.
REQ-025 SHALL be a single module; the compare/subtract datapath is inline and has no sub-module.

Verification
REQ-026 Dividend=100, Divisor=7, Start pulse -> Done after 15 edges in RUN, Quotient=14, Remainder=2, DivZero=0.
REQ-027 Dividend=5, Divisor=9 -> Done after 1 RUN edge, Quotient=0, Remainder=5.
REQ-028 Dividend=1023, Divisor=1 -> Quotient=1023, Remainder=0, Done after 1024 RUN edges, no wrap.
REQ-029 Dividend=50, Divisor=0 -> Done on the cycle after acceptance, DivZero=1, Quotient=10'h3FF, Remainder=0.
REQ-030 Start 100/7, assert Reset at RUN edge 5 -> next cycle IDLE, Ready=1, all outputs 0, no Done pulse.
REQ-031 Start 100/7, pulse Start with 200/3 mid-RUN -> ignored; result is 14/2; Ready=0 throughout RUN.
